// File: rtl/load_store_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit_if : request/response handshake plus data-memory bus       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic [31:0] DataRd;

  // The unit serves requests and drives the memory bus.
  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, DataRd,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
           Address, DataWr, DMWr, DMCtrl
  );

  // The environment issues requests and implements the memory.
  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, DataRd,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
           Address, DataWr, DMWr, DMCtrl
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_store_unit : data-memory initiator, one request at a time, splits     |
// | misaligned halfword/word accesses into byte accesses.  Revision 1.0        |
// +----------------------------------------------------------------------------+
module load_store_unit #(
  parameter int MEM_BYTES        = 2048,
  parameter int SPLIT_MISALIGNED = 1
) (
  input  wire                     clk,
  input  wire                     rst_n,
  load_store_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_SPLIT  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [32:0] c_mem_limit = 33'(MEM_BYTES);

  state_t      r_state;
  state_t      w_next;
  logic        r_we;
  logic [2:0]  r_ctrl;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_asm;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [1:0]  r_cnt;

  logic        w_accept;
  logic [2:0]  w_size;
  logic        w_illegal;
  logic [32:0] w_end;
  logic        w_oor;
  logic        w_misal;
  logic        w_fault;
  logic [1:0]  w_last;
  logic        w_split_done;
  logic [31:0] w_asm_next;
  logic [31:0] w_ext;
  logic [31:0] w_address;
  logic [31:0] w_datawr;
  logic        w_dmwr;
  logic [2:0]  w_dmctrl;

  assign bus.req_ready = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_comb begin
    w_size = 3'd4;
    case (bus.req_ctrl[1:0])
      2'b00:   w_size = 3'd1;
      2'b01:   w_size = 3'd2;
      default: w_size = 3'd4;
    endcase
  end

  // Range end computed in 33 bits so an access wrapping past 0xFFFFFFFF faults.
  assign w_illegal = (bus.req_ctrl == 3'b011) || (bus.req_ctrl == 3'b110) ||
                     (bus.req_ctrl == 3'b111);
  assign w_end     = {1'b0, bus.req_addr} + {30'b0, w_size} - 33'd1;
  assign w_oor     = (w_end >= c_mem_limit);
  assign w_misal   = ((bus.req_ctrl[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_ctrl[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_fault   = w_illegal || w_oor || (w_misal && (SPLIT_MISALIGNED == 0));

  assign w_last       = (r_ctrl[1:0] == 2'b01) ? 2'd1 : 2'd3;
  assign w_split_done = (r_cnt == w_last);

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_cnt, 3'b000} +: 8] = bus.DataRd[7:0];
    case (r_ctrl)
      3'b001:  w_ext = {{16{w_asm_next[15]}}, w_asm_next[15:0]};
      3'b101:  w_ext = {16'b0, w_asm_next[15:0]};
      default: w_ext = w_asm_next;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (w_fault)      w_next = S_RESP;
          else if (w_misal) w_next = S_SPLIT;
          else              w_next = S_ACCESS;
        end else if (r_state == S_RESP) begin
          w_next = S_IDLE;
        end
      end
      S_ACCESS: w_next = S_RESP;
      S_SPLIT:  if (w_split_done) w_next = S_RESP;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus is purely a function of state so reset drops DMWr without waiting for a clock.
  always_comb begin
    w_address = 32'd0;
    w_datawr  = 32'd0;
    w_dmwr    = 1'b0;
    w_dmctrl  = 3'b010;
    case (r_state)
      S_ACCESS: begin
        w_address = r_addr;
        w_datawr  = r_wdata;
        w_dmwr    = r_we;
        w_dmctrl  = r_ctrl;
      end
      S_SPLIT: begin
        w_address = r_addr + {30'b0, r_cnt};
        w_datawr  = {24'b0, r_wdata[{r_cnt, 3'b000} +: 8]};
        w_dmwr    = r_we;
        w_dmctrl  = r_we ? 3'b000 : 3'b100;
      end
      default: ;
    endcase
  end

  assign bus.Address   = w_address;
  assign bus.DataWr    = w_datawr;
  assign bus.DMWr      = w_dmwr;
  assign bus.DMCtrl    = w_dmctrl;
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_fault = r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_ctrl  <= 3'b010;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_asm   <= 32'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_ctrl  <= bus.req_ctrl;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_asm   <= 32'd0;
        r_cnt   <= 2'd0;
        if (w_fault) begin
          r_rdata <= 32'd0;
          r_fault <= 1'b1;
        end
      end
      case (r_state)
        S_ACCESS: begin
          r_rdata <= r_we ? 32'd0 : bus.DataRd;
          r_fault <= 1'b0;
        end
        S_SPLIT: begin
          r_asm <= w_asm_next;
          r_cnt <= r_cnt + 2'd1;
          if (w_split_done) begin
            r_rdata <= r_we ? 32'd0 : w_ext;
            r_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_store_unit : directed stimulus, byte-array memory, queue model     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if b0 ();
  load_store_unit_if b1 ();

  load_store_unit #(.MEM_BYTES(2048), .SPLIT_MISALIGNED(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  load_store_unit #(.MEM_BYTES(2048), .SPLIT_MISALIGNED(0)) u_dut_nosplit (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  // Bus-side memory answering the DUT
  logic [7:0]  mem [0:2047];
  logic [10:0] ra0, ra1, ra2, ra3;
  logic [31:0] rw;
  assign ra0 = b0.Address[10:0];
  assign ra1 = ra0 + 11'd1;
  assign ra2 = ra0 + 11'd2;
  assign ra3 = ra0 + 11'd3;
  assign rw  = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};

  always_comb begin
    case (b0.DMCtrl)
      3'b000:  b0.DataRd = {{24{rw[7]}}, rw[7:0]};
      3'b100:  b0.DataRd = {24'b0, rw[7:0]};
      3'b001:  b0.DataRd = {{16{rw[15]}}, rw[15:0]};
      3'b101:  b0.DataRd = {16'b0, rw[15:0]};
      default: b0.DataRd = rw;
    endcase
  end
  assign b1.DataRd = 32'd0;

  always @(posedge clk) begin
    if (b0.DMWr) begin
      mem[ra0] <= b0.DataWr[7:0];
      if (b0.DMCtrl[1:0] != 2'b00) mem[ra1] <= b0.DataWr[15:8];
      if (b0.DMCtrl[1:0] == 2'b10) begin
        mem[ra2] <= b0.DataWr[23:16];
        mem[ra3] <= b0.DataWr[31:24];
      end
    end
  end

  // Reference model: request-level memory image and expected-response queue
  typedef struct { int due; logic [31:0] d; logic f; } exp_t;
  exp_t       exp_q [$];
  logic [7:0] ref_mem [0:2047];

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]     = init_byte(i);
      ref_mem[i] = init_byte(i);
    end
  end

  task automatic model_accept(input logic we, input logic [2:0] ctrl,
                              input logic [31:0] addr, input logic [31:0] wd);
    int sz; logic bad; exp_t e; logic [31:0] raw;
    case (ctrl)
      3'b000, 3'b100: begin sz = 1; bad = 1'b0; end
      3'b001, 3'b101: begin sz = 2; bad = 1'b0; end
      3'b010:         begin sz = 4; bad = 1'b0; end
      default:        begin sz = 1; bad = 1'b1; end
    endcase
    if ({32'b0, addr} + 64'(sz) - 64'd1 >= 64'd2048) bad = 1'b1;
    e.f = bad;
    e.d = 32'd0;
    if (bad)                 e.due = cyc + 1;
    else if (addr % sz == 0) e.due = cyc + 2;
    else                     e.due = cyc + sz + 1;
    if (!bad) begin
      raw = 32'd0;
      for (int i = 0; i < sz; i++) begin
        if (we) ref_mem[addr + i] = wd[8*i +: 8];
        raw[8*i +: 8] = ref_mem[addr + i];
      end
      if (!we) begin
        case (ctrl)
          3'b000:  e.d = {{24{raw[7]}}, raw[7:0]};
          3'b001:  e.d = {{16{raw[15]}}, raw[15:0]};
          default: e.d = raw;
        endcase
      end
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (b0.req_valid && b0.req_ready)
        model_accept(b0.req_we, b0.req_ctrl, b0.req_addr, b0.req_wdata);
      cyc++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b0.DMWr) chk("dmwr_outside_access", {31'b0, b0.req_ready}, 32'd0);
      if (b0.rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_rdata", b0.rsp_rdata, e.d);
          chk("rsp_fault", {31'b0, b0.rsp_fault}, {31'b0, e.f});
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        chk("rsp_missing", 32'd0, 32'd1);
        e = exp_q.pop_front();
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] ctrl,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n;
    b0.req_valid = 1'b1;
    b0.req_we    = we;
    b0.req_ctrl  = ctrl;
    b0.req_addr  = addr;
    b0.req_wdata = wd;
    n = 0;
    while (!b0.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b0.req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic expect_rsp(input string nm, input int lat, input logic [31:0] d,
                            input logic f, input int nw_exp, output logic [31:0] fa,
                            output logic [31:0] fd, output logic [31:0] pk);
    int k, nw;
    b0.req_valid = 1'b0;
    k = 1; nw = 0; fa = 0; fd = 0; pk = 0;
    forever begin
      if (b0.DMWr) begin
        if (nw == 0) begin fa = b0.Address; fd = b0.DataWr; end
        pk = {pk[23:0], b0.DataWr[7:0]};
        nw++;
      end
      if (b0.rsp_valid || k >= 20) break;
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, lat);
    chk({nm, "_rdata"}, b0.rsp_rdata, d);
    chk({nm, "_fault"}, {31'b0, b0.rsp_fault}, {31'b0, f});
    chk({nm, "_dmwr_pulses"}, nw, nw_exp);
  endtask

  logic [31:0] fa, fd, pk;
  int t1, t2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.req_valid = 0; b0.req_we = 0; b0.req_ctrl = 0; b0.req_addr = 0; b0.req_wdata = 0;
    b1.req_valid = 0; b1.req_we = 0; b1.req_ctrl = 0; b1.req_addr = 0; b1.req_wdata = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", {31'b0, b0.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, b0.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", b0.rsp_rdata, 32'd0);
    chk("reset_rsp_fault", {31'b0, b0.rsp_fault}, 32'd0);
    chk("reset_address", b0.Address, 32'd0);
    chk("reset_datawr", b0.DataWr, 32'd0);
    chk("reset_dmwr", {31'b0, b0.DMWr}, 32'd0);
    chk("reset_dmctrl", {29'b0, b0.DMCtrl}, 32'd2);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word store / load
    send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    expect_rsp("st_w10", 2, 32'd0, 1'b0, 1, fa, fd, pk);
    chk("st_w10_addr", fa, 32'h10);
    chk("st_w10_data", fd, 32'hDEADBEEF);
    send(1'b0, 3'b010, 32'h10, 32'h0);
    expect_rsp("ld_w10", 2, 32'hDEADBEEF, 1'b0, 0, fa, fd, pk);

    // Extension
    send(1'b1, 3'b000, 32'h20, 32'h80);
    expect_rsp("st_b20", 2, 32'd0, 1'b0, 1, fa, fd, pk);
    send(1'b0, 3'b000, 32'h20, 32'h0);
    expect_rsp("ld_b20", 2, 32'hFFFFFF80, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b100, 32'h20, 32'h0);
    expect_rsp("ld_bu20", 2, 32'h00000080, 1'b0, 0, fa, fd, pk);
    send(1'b1, 3'b001, 32'h22, 32'h8001);
    expect_rsp("st_h22", 2, 32'd0, 1'b0, 1, fa, fd, pk);
    send(1'b0, 3'b001, 32'h22, 32'h0);
    expect_rsp("ld_h22", 2, 32'hFFFF8001, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b101, 32'h22, 32'h0);
    expect_rsp("ld_hu22", 2, 32'h00008001, 1'b0, 0, fa, fd, pk);

    // Misaligned split
    send(1'b1, 3'b010, 32'h31, 32'h11223344);
    expect_rsp("st_w31", 5, 32'd0, 1'b0, 4, fa, fd, pk);
    chk("st_w31_first_addr", fa, 32'h31);
    chk("st_w31_bytes", pk, 32'h44332211);
    send(1'b0, 3'b010, 32'h31, 32'h0);
    expect_rsp("ld_w31", 5, 32'h11223344, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b001, 32'h11, 32'h0);
    expect_rsp("ld_h11", 3, 32'hFFFFADBE, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b101, 32'h11, 32'h0);
    expect_rsp("ld_hu11", 3, 32'h0000ADBE, 1'b0, 0, fa, fd, pk);

    // Faults and range boundary
    send(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
    expect_rsp("f_ctrl011", 1, 32'd0, 1'b1, 0, fa, fd, pk);
    send(1'b0, 3'b010, 32'h7FE, 32'h0);
    expect_rsp("f_w7fe", 1, 32'd0, 1'b1, 0, fa, fd, pk);
    send(1'b0, 3'b010, 32'h7FC, 32'h0);
    expect_rsp("ld_w7fc", 2, 32'hA5A4A7A6, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0);
    expect_rsp("f_wrap", 1, 32'd0, 1'b1, 0, fa, fd, pk);
    send(1'b1, 3'b111, 32'h40, 32'h12);
    expect_rsp("f_ctrl111", 1, 32'd0, 1'b1, 0, fa, fd, pk);

    // Back-to-back loads with req_valid held
    send(1'b0, 3'b010, 32'h10, 32'h0);
    t1 = cyc;
    send(1'b0, 3'b010, 32'h7FC, 32'h0);
    t2 = cyc;
    chk("b2b_accept_gap", t2 - t1, 32'd2);
    expect_rsp("b2b_second", 2, 32'hA5A4A7A6, 1'b0, 0, fa, fd, pk);
    @(negedge clk);

    // Reset during byte 2 of a split word store
    send(1'b1, 3'b010, 32'h51, 32'hAABBCCDD);
    b0.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_split_dmwr_before", {31'b0, b0.DMWr}, 32'd1);
    chk("rst_split_addr_before", b0.Address, 32'h53);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_split_dmwr_async", {31'b0, b0.DMWr}, 32'd0);
    chk("rst_split_ready", {31'b0, b0.req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[32'h53] = init_byte(32'h53);
    ref_mem[32'h54] = init_byte(32'h54);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'b0, b0.rsp_valid}, 32'd0);
    end
    send(1'b0, 3'b100, 32'h51, 32'h0);
    expect_rsp("rst_b51", 2, 32'h000000DD, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b100, 32'h52, 32'h0);
    expect_rsp("rst_b52", 2, 32'h000000CC, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b100, 32'h53, 32'h0);
    expect_rsp("rst_b53", 2, 32'h00000009, 1'b0, 0, fa, fd, pk);
    send(1'b0, 3'b100, 32'h54, 32'h0);
    expect_rsp("rst_b54", 2, 32'h0000000E, 1'b0, 0, fa, fd, pk);
    @(negedge clk);

    // No-split instance: misaligned faults, aligned proceeds
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_ctrl = 3'b001;
    b1.req_addr = 32'h41; b1.req_wdata = 32'h1234;
    chk("ns_ready", {31'b0, b1.req_ready}, 32'd1);
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("ns_h41_rsp_valid", {31'b0, b1.rsp_valid}, 32'd1);
    chk("ns_h41_fault", {31'b0, b1.rsp_fault}, 32'd1);
    chk("ns_h41_dmwr", {31'b0, b1.DMWr}, 32'd0);
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_addr = 32'h40;
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("ns_h40_dmwr", {31'b0, b1.DMWr}, 32'd1);
    chk("ns_h40_addr", b1.Address, 32'h40);
    @(negedge clk);
    chk("ns_h40_rsp_valid", {31'b0, b1.rsp_valid}, 32'd1);
    chk("ns_h40_fault", {31'b0, b1.rsp_fault}, 32'd0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) chk("rsp_outstanding", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
